// File: rtl/svm_rom_sequencer_pkg.sv
// Shared types and default sizing for the SVM ROM row sequencer.
// The optional CEB gating is selected by SVM_SEQ_CEB_GATE_EN in the top module.
package svm_seq_pkg;

  localparam int SVM_ROM_DEPTH     = 1024;
  localparam int SVM_LOG_ROM_DEPTH = $clog2(SVM_ROM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/svm_rom_sequencer_if.sv
// Control, ROM-address and row-output signals of the SVM ROM sequencer.
// The sequencer takes the slave view; the controller/consumer side takes master.
interface svm_rom_sequencer_if
  import svm_seq_pkg::*;
#(
  parameter int LOG_ROM_DEPTH = SVM_LOG_ROM_DEPTH
);
  logic                     start;
  logic [LOG_ROM_DEPTH:0]   num_sv;
  logic                     start_ready;
  logic [LOG_ROM_DEPTH-1:0] rom_addr;
  logic                     rom_ceb;
  logic                     out_valid;
  logic                     out_ready;
  logic [LOG_ROM_DEPTH-1:0] out_index;
  logic                     out_last;
  logic                     done;

  modport master (
    output start, num_sv, out_ready,
    input  start_ready, rom_addr, rom_ceb, out_valid, out_index, out_last, done
  );

  modport slave (
    input  start, num_sv, out_ready,
    output start_ready, rom_addr, rom_ceb, out_valid, out_index, out_last, done
  );
endinterface

// File: rtl/svm_rom_sequencer.sv
// Sweeps ROM rows 0..num_sv-1 through a 1-cycle-latency ROM with a valid/ready output.
// Define SVM_SEQ_CEB_GATE_EN to drive rom_ceb low only on address-issue cycles.
module svm_rom_sequencer
  import svm_seq_pkg::*;
#(
  parameter int ROM_DEPTH     = SVM_ROM_DEPTH,
  parameter int LOG_ROM_DEPTH = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  svm_rom_sequencer_if.slave    bus
);

  localparam int CW = LOG_ROM_DEPTH + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(ROM_DEPTH);

  seq_state_e               state_q, state_d;
  cnt_t                     issue_cnt_q, issue_cnt_d;
  cnt_t                     num_q, num_d;
  logic [LOG_ROM_DEPTH-1:0] out_index_q, out_index_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     done_q, done_d;
  logic                     start_ready_q, start_ready_d;

  logic stall, issue, transfer, accept, last_issue;

  always_comb begin
    stall      = out_valid_q && !bus.out_ready;
    transfer   = out_valid_q && bus.out_ready;
    issue      = (state_q == S_RUN) && !stall;
    accept     = bus.start && start_ready_q && !rst;
    last_issue = (issue_cnt_q == (num_q - cnt_t'(1)));
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    num_d       = num_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (transfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.num_sv == '0) begin
            state_d = S_DONE;
          end else begin
            num_d       = (bus.num_sv > DEPTH_C) ? DEPTH_C : bus.num_sv;
            issue_cnt_d = '0;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          out_valid_d = 1'b1;
          out_index_d = issue_cnt_q[LOG_ROM_DEPTH-1:0];
          out_last_d  = last_issue;
          // Counter parks on the final row so the address never wraps past ROM_DEPTH-1.
          if (last_issue) begin
            state_d = S_DRAIN;
          end else begin
            issue_cnt_d = issue_cnt_q + cnt_t'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d        = (state_d == S_DONE);
    start_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      issue_cnt_q   <= '0;
      num_q         <= '0;
      out_index_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      done_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      num_q         <= num_d;
      out_index_q   <= out_index_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      done_q        <= done_d;
      start_ready_q <= start_ready_d;
    end
  end

  // Re-presenting the held row's address keeps mem_out stable through a stall.
  assign bus.rom_addr    = stall ? out_index_q : issue_cnt_q[LOG_ROM_DEPTH-1:0];
  assign bus.start_ready = start_ready_q && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_index   = out_index_q;
  assign bus.out_last    = out_last_q;
  assign bus.done        = done_q;

`ifdef SVM_SEQ_CEB_GATE_EN
  assign bus.rom_ceb = !issue;
`else
  assign bus.rom_ceb = 1'b0;
`endif

endmodule

// File: tb/tb_svm_rom_sequencer.sv
// Self-checking bench for svm_rom_sequencer: directed table, stall/reset sequences, random sweeps.
module tb_svm_rom_sequencer;
  import svm_seq_pkg::*;

  localparam int DEPTH = SVM_ROM_DEPTH;
  localparam int LW    = SVM_LOG_ROM_DEPTH;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] mem_out;

  int checks = 0;
  int errors = 0;

  svm_rom_sequencer_if #(.LOG_ROM_DEPTH(LW)) bus ();

  svm_rom_sequencer #(.ROM_DEPTH(DEPTH), .LOG_ROM_DEPTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [LW-1:0] a);
    return {a[5:0], a} ^ 16'h5A3C;
  endfunction

  // ROM macro model: 1-cycle read, Q retained while CEB is high.
  always @(posedge clk) begin
    if (!bus.rom_ceb) mem_out <= rom_word(bus.rom_addr);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // mode 0: out_ready high; 1: random ready and stray starts; 2: ready low on cycles 3..5
  task automatic run_sweep(input int n, input int mode, input int exp_beats, input int exp_done);
    int n_eff, c, exp_idx, beats, done_cyc, first_cyc, last_cyc, ceb_lo, ceb_hi, limit;
    bit fin;
    n_eff = (n > DEPTH) ? DEPTH : n;
    exp_idx = 0; beats = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
    ceb_lo = 0; ceb_hi = 0; fin = 0;
    limit = 8 * n_eff + 40;
    @(negedge clk);
    chk("start_ready_idle", bus.start_ready, 1);
    bus.start = 1'b1;
    bus.num_sv = (LW+1)'(n);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    while (!fin) begin
      case (mode)
        0: bus.out_ready = 1'b1;
        2: bus.out_ready = !(c >= 3 && c <= 5);
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 1) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.num_sv = (LW+1)'($urandom_range(0, 50));
      end
      @(negedge clk);
      if (!bus.rom_ceb) ceb_lo++; else ceb_hi++;
      if (bus.out_valid) begin
        chk("out_index", bus.out_index, exp_idx);
        chk("out_last", bus.out_last, (exp_idx == n_eff - 1) ? 1 : 0);
        chk("mem_out", mem_out, rom_word(bus.out_index));
        chk("addr_nowrap", (bus.rom_addr >= bus.out_index) ? 1 : 0, 1);
        if (!bus.out_ready) chk("stall_addr", bus.rom_addr, bus.out_index);
        if (mode == 2 && c >= 3 && c <= 5) chk("stall_addr_1", bus.rom_addr, 1);
        if (bus.out_ready) begin
          if (beats == 0) first_cyc = c;
          last_cyc = c;
          exp_idx++;
          beats++;
        end
      end
      if (bus.done) begin
        done_cyc = c;
        fin = 1;
      end else if (c > limit) begin
        chk("done_timeout", 0, 1);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        c++;
      end
    end
    bus.start = 1'b0;
    chk("beats", beats, exp_beats);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    if (mode == 0 && n_eff > 0) begin
      chk("first_beat_cycle", first_cyc, 2);
      chk("last_beat_cycle", last_cyc, n_eff + 1);
    end
`ifdef SVM_SEQ_CEB_GATE_EN
    chk("ceb_issue_cycles", ceb_lo, n_eff);
`else
    chk("ceb_const_low", ceb_hi, 0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single_pulse", bus.done, 0);
    chk("start_ready_after", bus.start_ready, 1);
    $display("sweep num_sv=%0d mode=%0d beats=%0d done_cycle=%0d", n, mode, beats, done_cyc);
  endtask

  typedef struct {
    int num;
    int mode;
    int exp_beats;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, done_seen;
    vecs[0] = '{num: 4,    mode: 0, exp_beats: 4,    exp_done: 7};
    vecs[1] = '{num: 0,    mode: 0, exp_beats: 0,    exp_done: 1};
    vecs[2] = '{num: 1,    mode: 0, exp_beats: 1,    exp_done: 4};
    vecs[3] = '{num: 3,    mode: 2, exp_beats: 3,    exp_done: 9};
    vecs[4] = '{num: 1024, mode: 0, exp_beats: 1024, exp_done: 1027};
    vecs[5] = '{num: 1100, mode: 0, exp_beats: 1024, exp_done: 1027};
    vecs[6] = '{num: 5,    mode: 1, exp_beats: 5,    exp_done: -1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_sv = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_ready_in_reset", bus.start_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_start_ready", bus.start_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i].num, vecs[i].mode, vecs[i].exp_beats, vecs[i].exp_done);
    end

    // Reset on the 3rd beat of an 8-row sweep.
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_sv = (LW+1)'(8);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_third_beat", bus.out_index, 2);
    chk("midrst_ready_low", bus.start_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_rom_addr", bus.rom_addr, 0);
    chk("midrst_out_index", bus.out_index, 0);
    chk("midrst_start_ready", bus.start_ready, 1);
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    chk("midrst_no_done", done_seen, 0);
    $display("reset mid-sweep num_sv=8 done_pulses=%0d", done_seen);
    run_sweep(2, 0, 2, 5);

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 40);
      run_sweep(n, 1, n, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
